bcd2bin_hh_2dig: RTL and testbench
==================================

Name: bcd2bin_hh_2dig

Overview:
- Sequential two-digit BCD-to-binary loader for the hours field; it is the inverse of the binary-to-BCD hours counter.
- Accepts a packed BCD byte (tens in [7:4], units in [3:0]), e.g. an hours value read back from the RTC or entered on the display path.
- Validates the byte, converts it by iterative add-ten, and presents a binary hour (0..MAX_VAL) with done/error pulses.
- Its output preloads the hours counter after an RTC read.

Parameters:
N, 5, width of binary output (enough for MAX_VAL)
MAX_VAL, 23, largest legal converted value; anything above is flagged as an error

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
data_BCD  input  8  packed BCD: [7:4] tens digit, [3:0] units digit
start  input  1  conversion request, sampled only when ready=1
ready  output  1  high when idle and able to accept start
busy  output  1  high while a conversion is in progress (not IDLE)
done  output  1  one-cycle pulse: hour_bin updated with a valid result
err  output  1  one-cycle pulse: input rejected, hour_bin unchanged
hour_bin  output  N  last valid converted hour, held until the next valid conversion

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; internal tens/acc registers cleared.
  - hour_bin=0, done=0, err=0, busy=0, ready=1 (ready follows IDLE once reset is released).
  - Reset mid-conversion aborts the conversion; no done/err pulse is produced.
- State machine: IDLE, CHECK, CONV, DONE, ERR.
- IDLE: ready=1. On start=1 at a rising edge, latch tens=data_BCD[7:4] and units=data_BCD[3:0]; go to CHECK. start when not IDLE is ignored, not queued.
- CHECK: if tens>9 or units>9, go to ERR. Else acc(7 bits)=units, go to CONV.
- CONV (one cycle per iteration):
  - If tens!=0: acc=acc+10, tens=tens-1, stay in CONV.
  - If tens==0 and acc<=MAX_VAL: hour_bin=acc[N-1:0], go to DONE.
  - If tens==0 and acc>MAX_VAL: go to ERR.
- DONE: done=1 for exactly one cycle; go to IDLE.
- ERR: err=1 for exactly one cycle; hour_bin untouched; go to IDLE.
- done and err are registered, mutually exclusive, and never both high.
- Latency: with tens digit d, start is accepted at edge k.
  - Valid input: done is high during the cycle after edge k+2+d; the total is d+3 cycles.
  - Digit error: err is high after edge k+1.
  - Range error: err is high after edge k+2+d.
- Back-to-back: ready returns one cycle after the done/err cycle. The minimum request spacing is d+4 cycles.
- Widths:
  - acc is 7 bits (max 99, no overflow).
  - hour_bin is truncated to N bits only after the range check.
  - All comparisons are unsigned.
- Boundaries:
  - 0x00 gives 0.
  - 0x23 gives 23 (MAX_VAL).
  - 0x24 gives err.
  - A hex nibble A..F in either digit gives err from CHECK, without entering CONV.

Test Plan:
- Reset held low then released; data_BCD=0x00, start pulse -> done after 3 cycles, hour_bin=0, err never high.
- data_BCD=0x23, start -> busy for 5 cycles, done pulse on cycle 5, hour_bin=23 (5'b10111).
- hour_bin=23 held; data_BCD=0x24, start -> err pulse after 5 cycles, hour_bin stays 23, done never asserted.
- data_BCD=0x1A then 0xA1 -> each gives an err pulse 2 cycles after start, CONV never entered, hour_bin unchanged.
- data_BCD=0x15, start held high continuously -> start ignored while busy; next accepted start is 1 cycle after the done pulse; hour_bin=15 for each.
- data_BCD=0x19, start, reset driven low 2 cycles later -> immediate hour_bin=0, ready=1 after release, no done/err pulse; a subsequent 0x07 gives hour_bin=7.

Source files
------------

// File: rtl/bcd2bin_hh_2dig.sv
// Sequential two-digit BCD-to-binary loader for the hours field.
// Validates a packed BCD byte, converts by iterative add-ten, and range-checks the result.
`timescale 1ns/1ps
module bcd2bin_hh_2dig #(
  parameter int unsigned N       = 5,
  parameter int unsigned MAX_VAL = 23
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   data_BCD,
  input  logic         start,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] hour_bin
);

  localparam int unsigned DIG_W = 4;
  localparam int unsigned ACC_W = 7;
  localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(9);
  localparam logic [ACC_W-1:0] ACC_TEN = ACC_W'(10);
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(MAX_VAL);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    CONV  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t             state, state_nx;
  logic [DIG_W-1:0]   tens, tens_nx;
  logic [DIG_W-1:0]   units, units_nx;
  logic [ACC_W-1:0]   acc, acc_nx;
  logic [N-1:0]       hour_nx;

  // Next-state and datapath updates
  always_comb begin
    state_nx = state;
    tens_nx  = tens;
    units_nx = units;
    acc_nx   = acc;
    hour_nx  = hour_bin;
    case (state)
      IDLE: begin
        if (start) begin
          tens_nx  = data_BCD[7:4];
          units_nx = data_BCD[3:0];
          state_nx = CHECK;
        end
      end
      CHECK: begin
        if ((tens > DIG_MAX) || (units > DIG_MAX)) begin
          state_nx = ERR;
        end else begin
          acc_nx   = ACC_W'(units);
          state_nx = CONV;
        end
      end
      CONV: begin
        if (tens != '0) begin
          acc_nx  = acc + ACC_TEN;
          tens_nx = tens - DIG_W'(1);
        end else if (acc <= ACC_MAX) begin
          // Truncate only after the range check has passed
          hour_nx  = N'(acc);
          state_nx = DONE;
        end else begin
          state_nx = ERR;
        end
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tens     <= '0;
      units    <= '0;
      acc      <= '0;
      hour_bin <= '0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      tens     <= tens_nx;
      units    <= units_nx;
      acc      <= acc_nx;
      hour_bin <= hour_nx;
      ready    <= (state_nx == IDLE);
      busy     <= (state_nx != IDLE);
      done     <= (state_nx == DONE);
      err      <= (state_nx == ERR);
    end
  end

endmodule

// File: tb/tb_bcd2bin_hh_2dig.sv
// Scoreboard bench for bcd2bin_hh_2dig: stimulus pushes expected pulses, a monitor pops and checks.
`timescale 1ns/1ps
module tb_bcd2bin_hh_2dig;

  localparam int unsigned N       = 5;
  localparam int unsigned MAX_VAL = 23;

  logic         clk;
  logic         reset;
  logic [7:0]   data_BCD;
  logic         start;
  logic         ready;
  logic         busy;
  logic         done;
  logic         err;
  logic [N-1:0] hour_bin;

  bcd2bin_hh_2dig #(.N(N), .MAX_VAL(MAX_VAL)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_BCD (data_BCD),
    .start    (start),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .hour_bin (hour_bin)
  );

  typedef struct {
    bit is_err;
    int hour;
    int acc_cyc;
    int exp_cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   model_hour = 0;
  bit   running = 0;
  bit   mon_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference model: decimal value of the BCD byte, judged against the hour range
  task automatic push(input logic [7:0] b);
    exp_t e;
    int t, u, v;
    t = int'(b[7:4]);
    u = int'(b[3:0]);
    e.acc_cyc = cyc + 1;
    if (t > 9 || u > 9) begin
      e.is_err  = 1'b1;
      e.exp_cyc = e.acc_cyc + 1;
    end else begin
      v = 10 * t + u;
      e.exp_cyc = e.acc_cyc + 2 + t;
      if (v > int'(MAX_VAL)) e.is_err = 1'b1;
      else begin
        e.is_err   = 1'b0;
        model_hour = v;
      end
    end
    e.hour = model_hour;
    sbq.push_back(e);
  endtask

  task automatic issue(input logic [7:0] b);
    int w = 0;
    while (!ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      fail_now("ready_timeout");
      return;
    end
    data_BCD = b;
    start    = 1'b1;
    push(b);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0) begin
      fail_now("drain_timeout");
      sbq.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: checks pulses, their timing, hour_bin, and ready/busy every cycle
  always @(negedge clk) begin
    if (running && reset) begin
      mon_busy = (sbq.size() > 0 && cyc >= sbq[0].acc_cyc) || done || err;
      chk("busy", int'(busy), int'(mon_busy));
      chk("ready", int'(ready), int'(!mon_busy));
      if (done || err) begin
        chk("done_err_exclusive", int'(done && err), 0);
        if (sbq.size() == 0) begin
          fail_now("unexpected_pulse");
        end else begin
          mon_e = sbq.pop_front();
          chk("pulse_cycle", cyc, mon_e.exp_cyc);
          chk("pulse_is_err", int'(err), int'(mon_e.is_err));
          chk("hour_bin", int'(hour_bin), mon_e.hour);
        end
      end else if (sbq.size() > 0 && sbq[0].exp_cyc < cyc) begin
        fail_now("missing_pulse");
        mon_e = sbq.pop_front();
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    int   last;
    logic [7:0] b;
    reset    = 1'b0;
    start    = 1'b0;
    data_BCD = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_hour_bin", int'(hour_bin), 0);
    chk("rst_ready", int'(ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    reset   = 1'b1;
    running = 1'b1;
    @(negedge clk);

    // Boundaries: zero, max legal value, first out-of-range, hex digits
    issue(8'h00); drain();
    issue(8'h23); drain();
    chk("hour_23_held", int'(hour_bin), 23);
    issue(8'h24); drain();
    chk("hour_after_range_err", int'(hour_bin), 23);
    issue(8'h1A); drain();
    issue(8'hA1); drain();
    chk("hour_after_digit_err", int'(hour_bin), 23);

    // start held high: later requests are accepted only once idle again
    data_BCD = 8'h15;
    start    = 1'b1;
    cnt      = 0;
    last     = 0;
    for (int i = 0; i < 60; i++) begin
      if (ready) begin
        if (cnt > 0) chk("held_spacing", cyc + 1 - last, 5);
        last = cyc + 1;
        push(8'h15);
        cnt++;
        if (cnt == 3) begin
          @(negedge clk);
          start = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    chk("held_accept_count", cnt, 3);
    start = 1'b0;
    drain();
    chk("hour_15", int'(hour_bin), 15);

    // Reset mid-conversion aborts with no pulse
    issue(8'h19);
    @(negedge clk);
    sbq.delete();
    model_hour = 0;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_hour_bin", int'(hour_bin), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_err", int'(err), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", int'(ready), 1);
    chk("abort_busy", int'(busy), 0);
    repeat (12) @(negedge clk);
    issue(8'h07); drain();
    chk("hour_7", int'(hour_bin), 7);

    // Randomized mix of arbitrary bytes, in-range hours and any BCD value
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 2))
        0: b = 8'($urandom);
        1: b = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
        default: b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      endcase
      issue(b);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    chk("final_hour", int'(hour_bin), model_hour);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
